bip_sequencer: RTL and testbench

BIP_SEQUENCER -- requirements
Module: bip_sequencer

---
 rtl/bip_pkg.sv | 37 +++
 rtl/bip_opcode_decoder.sv | 61 ++++++
 rtl/bip_sequencer.sv | 125 ++++++++++++
 tb/tb_bip_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared opcode constants, FSM states and mux encodings for the BIP sequencer.
package bip_pkg;

  localparam int OPC_W = 5;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;
  localparam logic [4:0] OPC_BEQ  = 5'b01000;
  localparam logic [4:0] OPC_BNE  = 5'b01001;
  localparam logic [4:0] OPC_BLT  = 5'b01010;
  localparam logic [4:0] OPC_JMP  = 5'b01011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  typedef enum logic [2:0] {
    BR_NONE   = 3'd0,
    BR_EQ     = 3'd1,
    BR_NE     = 3'd2,
    BR_LT     = 3'd3,
    BR_ALWAYS = 3'd4
  } branch_t;

endpackage

// File: rtl/bip_opcode_decoder.sv
// Pure combinational opcode decode into datapath strobes and a branch kind.
// Branch opcodes decode only when BIP_BRANCH_EN is defined; otherwise they fall to NOP.
module bip_opcode_decoder
  import bip_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [1:0] sel_a,
  output logic       sel_b,
  output logic       wr_acc,
  output logic       op,
  output logic       wr_ram,
  output logic       rd_ram,
  output logic       halt,
  output logic [2:0] branch
);

  always_comb begin
    sel_a  = SEL_A_RAM;
    sel_b  = 1'b0;
    wr_acc = 1'b0;
    op     = 1'b0;
    wr_ram = 1'b0;
    rd_ram = 1'b0;
    halt   = 1'b0;
    branch = BR_NONE;
    case (opcode)
      OPC_HLT: halt = 1'b1;
      OPC_STO: wr_ram = 1'b1;
      OPC_LD: begin
        sel_a  = SEL_A_RAM;
        rd_ram = 1'b1;
        wr_acc = 1'b1;
      end
      OPC_LDI: begin
        sel_a  = SEL_A_IMM;
        wr_acc = 1'b1;
      end
      OPC_ADD, OPC_SUB: begin
        sel_a  = SEL_A_ALU;
        sel_b  = 1'b0;
        rd_ram = 1'b1;
        wr_acc = 1'b1;
        op     = (opcode == OPC_SUB);
      end
      OPC_ADDI, OPC_SUBI: begin
        sel_a  = SEL_A_ALU;
        sel_b  = 1'b1;
        wr_acc = 1'b1;
        op     = (opcode == OPC_SUBI);
      end
`ifdef BIP_BRANCH_EN
      OPC_BEQ: branch = BR_EQ;
      OPC_BNE: branch = BR_NE;
      OPC_BLT: branch = BR_LT;
      OPC_JMP: branch = BR_ALWAYS;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_sequencer.sv
// BIP control sequencer: FETCH/EXEC/HALT FSM owning PC and the instruction register.
// Conditional branches and JMP are enabled by the BIP_BRANCH_EN macro (see bip_opcode_decoder).
module bip_sequencer
  import bip_pkg::*;
#(
  parameter int PC_W    = 11,
  parameter int INSTR_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               IMEM_VALID,
  input  logic [INSTR_W-1:0] IMEM_DATA,
  input  logic               ACC_ZERO,
  input  logic               ACC_NEG,
  output logic               IMEM_REQ,
  output logic [PC_W-1:0]    PC,
  output logic [1:0]         SEL_A,
  output logic               SEL_B,
  output logic               WR_ACC,
  output logic               OP,
  output logic               WR_RAM,
  output logic               RD_RAM,
  output logic [INSTR_W-6:0] OPERAND,
  output logic               HALTED
);

  localparam int OPERAND_W = INSTR_W - OPC_W;

  state_t               state;
  state_t               state_next;
  logic [INSTR_W-1:0]   ir;
  logic [PC_W-1:0]      pc;
  logic [PC_W-1:0]      pc_next;
  logic                 load_ir;
  logic                 taken;

  logic [1:0]           dec_sel_a;
  logic                 dec_sel_b;
  logic                 dec_wr_acc;
  logic                 dec_op;
  logic                 dec_wr_ram;
  logic                 dec_rd_ram;
  logic                 dec_halt;
  logic [2:0]           dec_branch;

  bip_opcode_decoder u_decoder (
    .opcode (ir[INSTR_W-1:OPERAND_W]),
    .sel_a  (dec_sel_a),
    .sel_b  (dec_sel_b),
    .wr_acc (dec_wr_acc),
    .op     (dec_op),
    .wr_ram (dec_wr_ram),
    .rd_ram (dec_rd_ram),
    .halt   (dec_halt),
    .branch (dec_branch)
  );

  assign PC      = pc;
  assign OPERAND = ir[OPERAND_W-1:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= FETCH;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (load_ir) ir <= IMEM_DATA;
      pc <= pc_next;
    end
  end

  // Strobes come straight from the decoder but only while in EXEC, so an
  // async reset (which forces FETCH) silences them in the same cycle.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load_ir    = 1'b0;
    taken      = 1'b0;
    IMEM_REQ   = 1'b0;
    HALTED     = 1'b0;
    SEL_A      = SEL_A_RAM;
    SEL_B      = 1'b0;
    WR_ACC     = 1'b0;
    OP         = 1'b0;
    WR_RAM     = 1'b0;
    RD_RAM     = 1'b0;
    case (state)
      FETCH: begin
        IMEM_REQ = !RESET;
        if (IMEM_VALID) begin
          load_ir    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        SEL_A  = dec_sel_a;
        SEL_B  = dec_sel_b;
        WR_ACC = dec_wr_acc;
        OP     = dec_op;
        WR_RAM = dec_wr_ram;
        RD_RAM = dec_rd_ram;
        case (branch_t'(dec_branch))
          BR_EQ:     taken = ACC_ZERO;
          BR_NE:     taken = !ACC_ZERO;
          BR_LT:     taken = ACC_NEG;
          BR_ALWAYS: taken = 1'b1;
          default:   taken = 1'b0;
        endcase
        if (dec_halt) begin
          state_next = HALT;
        end else begin
          pc_next    = taken ? PC_W'(ir[OPERAND_W-1:0]) : pc + PC_W'(1);
          state_next = FETCH;
        end
      end
      HALT: HALTED = 1'b1;
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_bip_sequencer.sv
// Randomized self-checking bench for bip_sequencer against an instruction-level model.
module tb_bip_sequencer;

  localparam int PC_W    = 11;
  localparam int INSTR_W = 16;
`ifdef BIP_BRANCH_EN
  localparam bit BRANCH_EN = 1'b1;
`else
  localparam bit BRANCH_EN = 1'b0;
`endif

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               IMEM_VALID = 1'b0;
  logic [INSTR_W-1:0] IMEM_DATA = '0;
  logic               ACC_ZERO = 1'b0;
  logic               ACC_NEG = 1'b0;
  logic               IMEM_REQ;
  logic [PC_W-1:0]    PC;
  logic [1:0]         SEL_A;
  logic               SEL_B, WR_ACC, OP, WR_RAM, RD_RAM, HALTED;
  logic [INSTR_W-6:0] OPERAND;

  logic               s_reset = 1'b1;
  logic               s_imem_valid = 1'b0;
  logic [INSTR_W-1:0] s_imem_data = '0;
  logic               s_imem_req;
  logic [3:0]         s_pc;
  logic [1:0]         s_sel_a;
  logic               s_sel_b, s_wr_acc, s_op, s_wr_ram, s_rd_ram, s_halted;
  logic [INSTR_W-6:0] s_operand;

  logic [6:0] strobes;
  assign strobes = {SEL_A, SEL_B, WR_ACC, OP, WR_RAM, RD_RAM};

  int compared = 0;
  int mismatched = 0;
  int modelPc = 0;
  logic [INSTR_W-1:0] modelIr = '0;

  always #5 CLK = ~CLK;

  bip_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .CLK(CLK), .RESET(RESET), .IMEM_VALID(IMEM_VALID), .IMEM_DATA(IMEM_DATA),
    .ACC_ZERO(ACC_ZERO), .ACC_NEG(ACC_NEG), .IMEM_REQ(IMEM_REQ), .PC(PC),
    .SEL_A(SEL_A), .SEL_B(SEL_B), .WR_ACC(WR_ACC), .OP(OP), .WR_RAM(WR_RAM),
    .RD_RAM(RD_RAM), .OPERAND(OPERAND), .HALTED(HALTED)
  );

  bip_sequencer #(.PC_W(4), .INSTR_W(INSTR_W)) dut_small (
    .CLK(CLK), .RESET(s_reset), .IMEM_VALID(s_imem_valid), .IMEM_DATA(s_imem_data),
    .ACC_ZERO(1'b0), .ACC_NEG(1'b0), .IMEM_REQ(s_imem_req), .PC(s_pc),
    .SEL_A(s_sel_a), .SEL_B(s_sel_b), .WR_ACC(s_wr_acc), .OP(s_op), .WR_RAM(s_wr_ram),
    .RD_RAM(s_rd_ram), .OPERAND(s_operand), .HALTED(s_halted)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected {SEL_A, SEL_B, WR_ACC, OP, WR_RAM, RD_RAM} for an instruction in EXEC.
  function automatic logic [6:0] expStrobes(input logic [4:0] opc);
    case (opc)
      5'b00001: return 7'b00_0_0_0_1_0;
      5'b00010: return 7'b00_0_1_0_0_1;
      5'b00011: return 7'b01_0_1_0_0_0;
      5'b00100: return 7'b10_0_1_0_0_1;
      5'b00101: return 7'b10_1_1_0_0_0;
      5'b00110: return 7'b10_0_1_1_0_1;
      5'b00111: return 7'b10_1_1_1_0_0;
      default:  return 7'b0;
    endcase
  endfunction

  function automatic int nextPc(input int pc, input logic [INSTR_W-1:0] instr,
                                input logic zero, input logic neg, input int pcw);
    logic [4:0] opc = instr[INSTR_W-1:INSTR_W-5];
    bit taken;
    taken = BRANCH_EN && ((opc == 5'b01011) || (opc == 5'b01000 && zero) ||
                          (opc == 5'b01001 && !zero) || (opc == 5'b01010 && neg));
    if (taken) return int'(instr[INSTR_W-6:0]) % (1 << pcw);
    return (pc + 1) % (1 << pcw);
  endfunction

  task automatic doReset();
    RESET = 1'b1;
    IMEM_VALID = 1'b0;
    @(negedge CLK);
    checkOutput("reset_pc", 32'(PC), 32'd0);
    checkOutput("reset_strobes", 32'(strobes), 32'd0);
    checkOutput("reset_operand", 32'(OPERAND), 32'd0);
    checkOutput("reset_halted", 32'(HALTED), 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    modelPc = 0;
    modelIr = '0;
  endtask

  // One full instruction: FETCH (with optional wait states) then EXEC.
  task automatic applyStimulus(input logic [INSTR_W-1:0] instr, input int waits,
                               input logic zero, input logic neg);
    logic [4:0] opc = instr[INSTR_W-1:INSTR_W-5];
    for (int i = 0; i <= waits; i++) begin
      IMEM_VALID = (i == waits);
      IMEM_DATA  = (i == waits) ? instr : INSTR_W'($urandom);
      @(negedge CLK);
      checkOutput("fetch_req", 32'(IMEM_REQ), 32'd1);
      checkOutput("fetch_pc", 32'(PC), 32'(modelPc));
      checkOutput("fetch_strobes", 32'(strobes), 32'd0);
      checkOutput("fetch_ir_hold", 32'(OPERAND), 32'(modelIr[INSTR_W-6:0]));
      @(posedge CLK);
      #1;
    end
    modelIr    = instr;
    IMEM_VALID = 1'($urandom);
    IMEM_DATA  = INSTR_W'($urandom);
    ACC_ZERO   = zero;
    ACC_NEG    = neg;
    @(negedge CLK);
    checkOutput("exec_strobes", 32'(strobes), 32'(expStrobes(opc)));
    checkOutput("exec_operand", 32'(OPERAND), 32'(instr[INSTR_W-6:0]));
    checkOutput("exec_req", 32'(IMEM_REQ), 32'd0);
    checkOutput("exec_halted", 32'(HALTED), 32'd0);
    @(posedge CLK);
    #1;
    if (opc == 5'b00000) begin
      for (int k = 0; k < 3; k++) begin
        IMEM_VALID = 1'b1;
        IMEM_DATA  = INSTR_W'($urandom);
        @(negedge CLK);
        checkOutput("halt_flag", 32'(HALTED), 32'd1);
        checkOutput("halt_req", 32'(IMEM_REQ), 32'd0);
        checkOutput("halt_pc", 32'(PC), 32'(modelPc));
        checkOutput("halt_strobes", 32'(strobes), 32'd0);
        @(posedge CLK);
        #1;
      end
    end else begin
      modelPc = nextPc(modelPc, instr, zero, neg, PC_W);
    end
  endtask

  initial begin
    logic [INSTR_W-1:0] instr;
    logic [4:0] opc;

    doReset();
    applyStimulus({5'b00011, 11'd5}, 0, 1'b0, 1'b0);
    applyStimulus({5'b00101, 11'd3}, 0, 1'b0, 1'b0);
    applyStimulus({5'b00000, 11'd0}, 0, 1'b0, 1'b0);
    checkOutput("prog_halt_pc", 32'(PC), 32'd2);

    doReset();
    applyStimulus({5'b00011, 11'h2a5}, 3, 1'b0, 1'b0);
    applyStimulus({5'b10000, 11'h111}, 3, 1'b1, 1'b1);

`ifdef BIP_BRANCH_EN
    applyStimulus({5'b01000, 11'h040}, 0, 1'b1, 1'b0);
    checkOutput("beq_taken_pc", 32'(PC), 32'h40);
    applyStimulus({5'b01000, 11'h040}, 0, 1'b0, 1'b0);
    checkOutput("beq_not_taken_pc", 32'(PC), 32'h41);
`else
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus({5'b11111, 11'h7ff}, 0, 1'b0, 1'b0);
    applyStimulus({5'b01011, 11'h010}, 0, 1'b0, 1'b0);
    checkOutput("jmp_disabled_pc", 32'(PC), 32'd4);
`endif

    IMEM_VALID = 1'b1;
    IMEM_DATA  = {5'b00001, 11'h123};
    @(negedge CLK);
    checkOutput("sto_fetch_pc", 32'(PC), 32'(modelPc));
    @(posedge CLK);
    #1 IMEM_VALID = 1'b0;
    @(negedge CLK);
    checkOutput("sto_exec_wr_ram", 32'(WR_RAM), 32'd1);
    #1 RESET = 1'b1;
    #1;
    checkOutput("sto_reset_wr_ram", 32'(WR_RAM), 32'd0);
    checkOutput("sto_reset_pc", 32'(PC), 32'd0);
    checkOutput("sto_reset_strobes", 32'(strobes), 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    modelPc = 0;
    modelIr = '0;
    applyStimulus({5'b00010, 11'h055}, 0, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'b00000 && $urandom_range(0, 3) != 0) opc = 5'b10000;
      instr = {opc, 11'($urandom)};
      applyStimulus(instr, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
      if (opc == 5'b00000) doReset();
    end

    // Narrow PC instance: sixteen NOPs must walk 0..15 and wrap back to 0.
    @(posedge CLK);
    #1 s_reset = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      s_imem_valid = 1'b1;
      s_imem_data  = {5'b11000, 11'h3ff};
      @(negedge CLK);
      checkOutput("small_pc", 32'(s_pc), 32'(i % 16));
      checkOutput("small_req", 32'(s_imem_req), 32'd1);
      @(posedge CLK);
      #1 s_imem_valid = 1'b0;
      @(negedge CLK);
      checkOutput("small_exec_strobes",
                  32'({s_sel_a, s_sel_b, s_wr_acc, s_op, s_wr_ram, s_rd_ram, s_halted}), 32'd0);
      @(posedge CLK);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
